// File: rtl/mc_controller_pkg.sv
// Shared types and encodings for the multicycle ARM controller.
// State enum, condition codes, ALU command/control and mux select constants.
package arm_mc_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH
  } state_e;

  localparam logic [3:0] COND_EQ = 4'b0000, COND_NE = 4'b0001, COND_CS = 4'b0010,
                         COND_CC = 4'b0011, COND_MI = 4'b0100, COND_PL = 4'b0101,
                         COND_VS = 4'b0110, COND_VC = 4'b0111, COND_HI = 4'b1000,
                         COND_LS = 4'b1001, COND_GE = 4'b1010, COND_LT = 4'b1011,
                         COND_GT = 4'b1100, COND_LE = 4'b1101, COND_AL = 4'b1110,
                         COND_NV = 4'b1111;

  // Funct[4:1] command field
  localparam logic [3:0] CMD_ADD = 4'b0100, CMD_SUB = 4'b0010, CMD_AND = 4'b0000,
                         CMD_ORR = 4'b1100, CMD_CMP = 4'b1010;

  localparam logic [1:0] ALUCTL_ADD = 2'b00, ALUCTL_SUB = 2'b01,
                         ALUCTL_AND = 2'b10, ALUCTL_ORR = 2'b11;

  localparam logic [1:0] SRCB_RD2 = 2'b00, SRCB_IMM = 2'b01, SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00, RES_DATA = 2'b01, RES_ALURES = 2'b10;

endpackage

// File: rtl/mc_controller_if.sv
// Controller <-> datapath/memory bundle; slave = controller side, master = datapath side.
interface mc_controller_if;
  logic [19:0] Instr;
  logic [3:0]  ALUFlags;
  logic        MemReady;
  logic        PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, ALUSrcA, MemErr;
  logic [1:0]  ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl;

  modport slave (
    input  Instr, ALUFlags, MemReady,
    output PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, ALUSrcA, MemErr,
           ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl
  );

  modport master (
    output Instr, ALUFlags, MemReady,
    input  PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, ALUSrcA, MemErr,
           ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl
  );
endinterface

// File: rtl/mc_controller_condlogic.sv
// ARM condition evaluation: Cond field against held NZCV flags (combinational).
module mc_condlogic
  import arm_mc_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] flags_i,
  output logic       cond_ex_o
);
  logic n, z, c, v, ge;

  assign {n, z, c, v} = flags_i;
  assign ge = (n == v);

  always_comb begin
    cond_ex_o = 1'b0;
    case (cond_i)
      COND_EQ: cond_ex_o = z;
      COND_NE: cond_ex_o = ~z;
      COND_CS: cond_ex_o = c;
      COND_CC: cond_ex_o = ~c;
      COND_MI: cond_ex_o = n;
      COND_PL: cond_ex_o = ~n;
      COND_VS: cond_ex_o = v;
      COND_VC: cond_ex_o = ~v;
      COND_HI: cond_ex_o = c & ~z;
      COND_LS: cond_ex_o = ~(c & ~z);
      COND_GE: cond_ex_o = ge;
      COND_LT: cond_ex_o = ~ge;
      COND_GT: cond_ex_o = ~z & ge;
      COND_LE: cond_ex_o = ~(~z & ge);
      COND_AL: cond_ex_o = 1'b1;
      default: cond_ex_o = 1'b0;
    endcase
  end
endmodule

// File: rtl/mc_controller.sv
// Multicycle ARM sequencer: FSM, NZCV flag register, condition latch, memory wait timer, ALU decode.
module mc_controller
  import arm_mc_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         reset,
  mc_controller_if.slave bus
);
  localparam int TW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO = TW'(TIMEOUT);

  state_e        state_q, state_d;
  logic [3:0]    flags_q, flags_d;
  logic          cond_q, cond_d;
  logic [TW-1:0] timer_q, timer_d;

  logic [3:0] cond, rd;
  logic [1:0] op;
  logic [5:0] funct;
  logic       cond_ex, waiting, timeout, no_write;
  logic [1:0] flag_w, alu_ctl;

  assign cond  = bus.Instr[19:16];
  assign op    = bus.Instr[15:14];
  assign funct = bus.Instr[13:8];
  assign rd    = bus.Instr[3:0];

  mc_condlogic u_condlogic (.cond_i(cond), .flags_i(flags_q), .cond_ex_o(cond_ex));

  always_comb begin
    alu_ctl  = ALUCTL_ADD;
    flag_w   = 2'b00;
    no_write = 1'b0;
    case (funct[4:1])
      CMD_ADD: begin alu_ctl = ALUCTL_ADD; flag_w = {2{funct[0]}}; end
      CMD_SUB: begin alu_ctl = ALUCTL_SUB; flag_w = {2{funct[0]}}; end
      CMD_AND: begin alu_ctl = ALUCTL_AND; flag_w = {funct[0], 1'b0}; end
      CMD_ORR: begin alu_ctl = ALUCTL_ORR; flag_w = {funct[0], 1'b0}; end
      CMD_CMP: begin alu_ctl = ALUCTL_SUB; flag_w = {2{funct[0]}}; no_write = 1'b1; end
      default: ;
    endcase
  end

  // A false-conditioned store never waits, so it cannot time out.
  assign waiting = (state_q == FETCH) || (state_q == MEMRD) || (state_q == MEMWR && cond_q);
  assign timeout = (TIMEOUT != 0) && waiting && !bus.MemReady && (timer_q == TMO);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= FETCH;
      flags_q <= '0;
      cond_q  <= 1'b0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
      cond_q  <= cond_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:   state_d = bus.MemReady ? DECODE : FETCH;
      DECODE: begin
        case (op)
          2'b01:   state_d = MEMADR;
          2'b00:   state_d = funct[5] ? EXECI : EXECR;
          2'b10:   state_d = BRANCH;
          default: state_d = FETCH;
        endcase
      end
      MEMADR:  state_d = funct[0] ? MEMRD : MEMWR;
      MEMRD:   state_d = bus.MemReady ? MEMWB : (timeout ? FETCH : MEMRD);
      MEMWR:   state_d = (!cond_q || bus.MemReady || timeout) ? FETCH : MEMWR;
      EXECR, EXECI: state_d = ALUWB;
      default: state_d = FETCH;
    endcase

    timer_d = '0;
    if (TIMEOUT != 0 && waiting && !bus.MemReady && !timeout) timer_d = timer_q + 1'b1;

    cond_d = (state_q == DECODE) ? cond_ex : cond_q;

    flags_d = flags_q;
    if (state_q == EXECR || state_q == EXECI) begin
      if (flag_w[1] && cond_q) flags_d[3:2] = bus.ALUFlags[3:2];
      if (flag_w[0] && cond_q) flags_d[1:0] = bus.ALUFlags[1:0];
    end
  end

  always_comb begin
    bus.PCWrite    = 1'b0;
    bus.IRWrite    = 1'b0;
    bus.MemWrite   = 1'b0;
    bus.RegWrite   = 1'b0;
    bus.AdrSrc     = 1'b0;
    bus.ALUSrcA    = 1'b0;
    bus.ALUSrcB    = SRCB_RD2;
    bus.ResultSrc  = RES_ALUOUT;
    bus.ALUControl = ALUCTL_ADD;
    bus.ImmSrc     = op;
    bus.RegSrc     = {op == 2'b01, op == 2'b10};
    bus.MemErr     = timeout && reset;
    case (state_q)
      FETCH: begin
        bus.ALUSrcA = 1'b1; bus.ALUSrcB = SRCB_FOUR; bus.ResultSrc = RES_ALURES;
        bus.IRWrite = bus.MemReady; bus.PCWrite = bus.MemReady;
      end
      DECODE: begin
        bus.ALUSrcA = 1'b1; bus.ALUSrcB = SRCB_FOUR; bus.ResultSrc = RES_ALURES;
      end
      MEMADR:  bus.ALUSrcB = SRCB_IMM;
      MEMRD:   bus.AdrSrc = 1'b1;
      MEMWB: begin
        bus.ResultSrc = RES_DATA;
        bus.RegWrite  = cond_q;
        bus.PCWrite   = cond_q && (rd == 4'd15);
      end
      MEMWR: begin bus.AdrSrc = 1'b1; bus.MemWrite = cond_q; end
      EXECR: bus.ALUControl = alu_ctl;
      EXECI: begin bus.ALUSrcB = SRCB_IMM; bus.ALUControl = alu_ctl; end
      ALUWB: begin
        bus.RegWrite = cond_q && !no_write;
        bus.PCWrite  = cond_q && !no_write && (rd == 4'd15);
      end
      BRANCH: begin
        bus.ALUSrcB = SRCB_IMM; bus.ResultSrc = RES_ALURES; bus.PCWrite = cond_q;
      end
      default: ;
    endcase
    if (!reset || timeout) begin
      bus.PCWrite  = 1'b0;
      bus.IRWrite  = 1'b0;
      bus.MemWrite = 1'b0;
      bus.RegWrite = 1'b0;
    end
  end
endmodule
